// File: rtl/ddbb256_cfg_enum.sv
// ddbb256_cfg_enum -- configuration-space enumerator for the 256-bit config bus.
// On start_i it walks devices 0..31 (function 0) on bus CFG_BUS. For each
// device whose vendor ID reads back as something other than 16'hFFFF, it does
// the following. It sizes BAR0..BAR2 and places them in [MEM_BASE, MEM_LIMIT].
// It writes the IRQ line and sets the command register.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   start_i              scan request pulse (ignored while busy_o)
//   busy_o / done_o      scan in progress / one-cycle end-of-scan pulse
//   err_o                sticky: window overflow or write timeout this scan
//   dev_count_o          devices found this scan
//   next_addr_o          next free window address
//   cs_config_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o   initiator side
//   ack_i, dat_i         responder side
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start_i
// S_PROBE   | read line 0 (vendor ID); a timeout counts as absent
// S_CHECK   | absent -> S_NEXT, present -> size BARs
// S_BAR_WR  | write all-ones to BAR k
// S_BAR_RD  | read line 0, keep BAR k lanes as the size mask
// S_BAR_SET | allocate and write BAR k (skipped when the mask is 0)
// S_IRQ_WR  | write IRQ line byte (line 1, byte 12)
// S_CMD_WR  | write command: mem + master, or master only if no memory
// S_NEXT    | advance device or finish
// S_DONE    | pulse done_o, drop busy_o

module ddbb256_cfg_enum #(
  parameter logic [7:0]  CFG_BUS   = 8'd0,
  parameter logic [31:0] MEM_BASE  = 32'h4000_0000,
  parameter logic [31:0] MEM_LIMIT = 32'h7FFF_FFFF,
  parameter logic [15:0] TIMEOUT   = 16'd255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [5:0]   dev_count_o,
  output logic [31:0]  next_addr_o,
  output logic         cs_config_o,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [31:0]  sel_o,
  output logic [31:0]  adr_o,
  output logic [255:0] dat_o,
  input  logic         ack_i,
  input  logic [255:0] dat_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_PROBE, S_CHECK, S_BAR_WR, S_BAR_RD, S_BAR_SET,
    S_IRQ_WR, S_CMD_WR, S_NEXT, S_DONE
  } state_t;

  state_t        r_state;
  logic [4:0]    r_dev;
  logic [1:0]    r_bar;
  logic [15:0]   r_timer;
  logic [15:0]   r_vendor;
  logic [31:0]   r_mask;
  logic          r_nomem;
  logic          r_busy, r_done, r_err;
  logic [5:0]    r_count;
  logic [31:0]   r_next;
  logic          r_cyc, r_we;
  logic [31:0]   r_sel, r_adr;
  logic [255:0]  r_dat;

  logic [31:0]   w_inv;
  logic [32:0]   w_base, w_size;
  logic [33:0]   w_end;
  logic          w_ovf;
  logic [31:0]   w_lane_rd;
  logic          w_acc, w_we;
  logic [31:0]   w_sel;
  logic [3:0]    w_line;
  logic [255:0]  w_dat;
  logic [31:0]   w_bar_sel;
  logic [7:0]    w_bar_sh;

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dev_count_o = r_count;
  assign next_addr_o = r_next;
  assign cs_config_o = r_cyc;
  assign cyc_o       = r_cyc;
  assign stb_o       = r_cyc;
  assign we_o        = r_we;
  assign sel_o       = r_sel;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;

  always_comb begin
    // Allocation is done in 33/34 bits so an address wrap shows up as overflow.
    w_inv     = ~r_mask;
    w_base    = ({1'b0, r_next} + {1'b0, w_inv}) & {1'b1, r_mask};
    w_size    = {1'b0, w_inv} + 33'd1;
    w_end     = {1'b0, w_base} + {1'b0, w_size} - 34'd1;
    w_ovf     = w_base[32] | (w_end > {2'b00, MEM_LIMIT});
    w_bar_sel = 32'h000F_0000 << {r_bar, 2'b00};
    w_bar_sh  = 8'd128 + {1'b0, r_bar, 5'd0};
    case (r_bar)
      2'd0:    w_lane_rd = dat_i[159:128];
      2'd1:    w_lane_rd = dat_i[191:160];
      default: w_lane_rd = dat_i[223:192];
    endcase
    w_acc  = 1'b0;
    w_we   = 1'b0;
    w_sel  = '0;
    w_line = '0;
    w_dat  = '0;
    case (r_state)
      S_PROBE:  begin w_acc = 1'b1; w_sel = 32'h0000_0003; end
      S_BAR_WR: begin
        w_acc = 1'b1; w_we = 1'b1; w_sel = w_bar_sel;
        w_dat = {224'd0, 32'hFFFF_FFFF} << w_bar_sh;
      end
      S_BAR_RD: begin w_acc = 1'b1; w_sel = w_bar_sel; end
      S_BAR_SET: begin
        w_acc = (r_mask != 32'd0); w_we = 1'b1; w_sel = w_bar_sel;
        w_dat = {224'd0, (w_ovf ? 32'd0 : w_base[31:0])} << w_bar_sh;
      end
      S_IRQ_WR: begin
        w_acc = 1'b1; w_we = 1'b1; w_line = 4'd1; w_sel = 32'h0000_1000;
        w_dat[103:96] = {3'b000, r_dev};
      end
      S_CMD_WR: begin
        w_acc = 1'b1; w_we = 1'b1; w_sel = 32'h0000_0300;
        w_dat[79:64] = r_nomem ? 16'h0004 : 16'h0006;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_dev    <= '0;
      r_bar    <= '0;
      r_timer  <= '0;
      r_vendor <= '0;
      r_mask   <= '0;
      r_nomem  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
      r_next   <= MEM_BASE;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_dev   <= '0;
          r_err   <= 1'b0;
          r_count <= '0;
          r_next  <= MEM_BASE;
          r_busy  <= 1'b1;
          r_state <= S_PROBE;
        end
        S_CHECK: begin
          if (r_vendor == 16'hFFFF) r_state <= S_NEXT;
          else begin
            r_count <= r_count + 6'd1;
            r_nomem <= 1'b0;
            r_bar   <= '0;
            r_state <= S_BAR_WR;
          end
        end
        S_NEXT: begin
          if (r_dev == 5'd31) r_state <= S_DONE;
          else begin
            r_dev   <= r_dev + 5'd1;
            r_state <= S_PROBE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_PROBE, S_BAR_WR, S_BAR_RD, S_BAR_SET, S_IRQ_WR, S_CMD_WR: begin
          if (!r_cyc) begin
            // Entering with the bus idle guarantees a gap cycle between accesses.
            if (w_acc) begin
              r_cyc   <= 1'b1;
              r_we    <= w_we;
              r_sel   <= w_sel;
              r_adr   <= {4'h0, CFG_BUS, r_dev, 6'd0, w_line, 5'd0};
              r_dat   <= w_dat;
              r_timer <= TIMEOUT - 16'd1;
              if (r_state == S_BAR_SET) begin
                if (w_ovf) begin
                  r_err   <= 1'b1;
                  r_nomem <= 1'b1;
                end else begin
                  r_next <= w_base[31:0] + w_size[31:0];
                end
              end
            end else begin
              // Unimplemented BAR: no write, move on.
              if (r_bar == 2'd2) r_state <= S_IRQ_WR;
              else begin
                r_bar   <= r_bar + 2'd1;
                r_state <= S_BAR_WR;
              end
            end
          end else if (ack_i || (r_timer == 16'd0)) begin
            r_cyc <= 1'b0;
            if (r_we && !ack_i) r_err <= 1'b1;
            case (r_state)
              S_PROBE: begin
                r_vendor <= ack_i ? dat_i[15:0] : 16'hFFFF;
                r_state  <= S_CHECK;
              end
              S_BAR_WR: r_state <= S_BAR_RD;
              S_BAR_RD: begin
                r_mask  <= ack_i ? w_lane_rd : 32'd0;
                r_state <= S_BAR_SET;
              end
              S_BAR_SET: begin
                if (r_bar == 2'd2) r_state <= S_IRQ_WR;
                else begin
                  r_bar   <= r_bar + 2'd1;
                  r_state <= S_BAR_WR;
                end
              end
              S_IRQ_WR: r_state <= S_CMD_WR;
              default:  r_state <= S_NEXT;
            endcase
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
